// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared stall/flush encodings and hazard FSM states
package pipe_hazard_ctrl_pkg;
  localparam logic [1:0] FS_RUN   = 2'b00;
  localparam logic [1:0] FS_STALL = 2'b01;
  localparam logic [1:0] FS_FLUSH = 2'b10;
  typedef enum logic {IDLE = 1'b0, REDIRECT_WAIT = 1'b1} state_t;
endpackage

// File: rtl/pipe_perf_cnt.sv
// pipe_perf_cnt: wrapping 32-bit hazard event counters
module pipe_perf_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        load_use,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events,
  output logic [31:0] load_use_cnt
);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
      load_use_cnt <= '0;
    end else begin
      stall_cycles <= stall_cycles + 32'(stall);
      flush_events <= flush_events + 32'(flush);
      load_use_cnt <= load_use_cnt + 32'(load_use);
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush/redirect control
// Optional perf counters when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4:0]            id_rs1_addr,
  input  logic [4:0]            id_rs2_addr,
  input  logic                  ex_mem_read,
  input  logic [4:0]            ex_rd_addr,
  input  logic                  br_taken,
  input  logic [ADDR_WIDTH-1:0] br_target,
  input  logic                  if_busy,
  input  logic                  mem_busy,
  output logic [1:0]            pc_ctrl,
  output logic [1:0]            if_id_ctrl,
  output logic [1:0]            id_ex_ctrl,
  output logic [1:0]            ex_mem_ctrl,
  output logic [1:0]            mem_wb_ctrl,
  output logic                  redirect_valid,
`ifdef PIPE_HAZARD_PERF_EN
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_events,
  output logic [31:0]           load_use_cnt,
`endif
  output logic [ADDR_WIDTH-1:0] redirect_pc
);
  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] target;
  logic                  redir, load_use, capture;
  assign capture  = br_taken && state == IDLE;
  assign redir    = br_taken || state == REDIRECT_WAIT;
  assign load_use = ex_mem_read && ex_rd_addr != 5'd0 &&
                    (ex_rd_addr == id_rs1_addr || ex_rd_addr == id_rs2_addr);
  // Any busy stage defers a pending redirect into REDIRECT_WAIT.
  assign state_nx    = (redir && (mem_busy || if_busy)) ? REDIRECT_WAIT : IDLE;
  assign redirect_pc = capture ? br_target : target;
  always_comb begin
    pc_ctrl        = reset ? FS_RUN :
                     (mem_busy || if_busy || (!redir && load_use)) ? FS_STALL : FS_RUN;
    if_id_ctrl     = reset ? FS_RUN : mem_busy ? FS_STALL : redir ? FS_FLUSH :
                     load_use ? FS_STALL : if_busy ? FS_FLUSH : FS_RUN;
    id_ex_ctrl     = reset ? FS_RUN : mem_busy ? FS_STALL :
                     (redir || load_use) ? FS_FLUSH : FS_RUN;
    ex_mem_ctrl    = reset ? FS_RUN : mem_busy ? FS_STALL : redir ? FS_FLUSH : FS_RUN;
    mem_wb_ctrl    = reset ? FS_RUN : mem_busy ? FS_FLUSH : FS_RUN;
    redirect_valid = !reset && !mem_busy && !if_busy && redir;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state  <= IDLE;
      target <= PC_ADDR;
    end else begin
      state <= state_nx;
      if (capture) target <= br_target;
    end
`ifdef PIPE_HAZARD_PERF_EN
  pipe_perf_cnt u_perf (
    .clk          (clk),
    .reset        (reset),
    .stall        (pc_ctrl == FS_STALL),
    .flush        (redirect_valid),
    .load_use     (!mem_busy && !redir && load_use),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events),
    .load_use_cnt (load_use_cnt)
  );
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of pipe_hazard_ctrl control, redirect and reset
// Perf counter checks are compiled in when PIPE_HAZARD_PERF_EN is defined.
module tb_pipe_hazard_ctrl;
  logic        clk, reset;
  logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic        ex_mem_read, br_taken, if_busy, mem_busy;
  logic [31:0] br_target, redirect_pc;
  logic [1:0]  pc_ctrl, if_id_ctrl, id_ex_ctrl, ex_mem_ctrl, mem_wb_ctrl;
  logic        redirect_valid;
  logic [9:0]  ctrl;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_events, load_use_cnt;
`endif
  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .id_rs1_addr    (id_rs1_addr),
    .id_rs2_addr    (id_rs2_addr),
    .ex_mem_read    (ex_mem_read),
    .ex_rd_addr     (ex_rd_addr),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .if_busy        (if_busy),
    .mem_busy       (mem_busy),
    .pc_ctrl        (pc_ctrl),
    .if_id_ctrl     (if_id_ctrl),
    .id_ex_ctrl     (id_ex_ctrl),
    .ex_mem_ctrl    (ex_mem_ctrl),
    .mem_wb_ctrl    (mem_wb_ctrl),
    .redirect_valid (redirect_valid),
`ifdef PIPE_HAZARD_PERF_EN
    .stall_cycles   (stall_cycles),
    .flush_events   (flush_events),
    .load_use_cnt   (load_use_cnt),
`endif
    .redirect_pc    (redirect_pc)
  );

  assign ctrl = {pc_ctrl, if_id_ctrl, id_ex_ctrl, ex_mem_ctrl, mem_wb_ctrl};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ctrl is {pc, if_id, id_ex, ex_mem, mem_wb}
  task automatic chk_all(input string tag, input logic [9:0] ec, input logic ev, input logic [31:0] ep);
    #1;
    chk({tag, ".ctrl"}, 32'(ctrl), 32'(ec));
    chk({tag, ".rv"}, 32'(redirect_valid), 32'(ev));
    chk({tag, ".pc"}, redirect_pc, ep);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; id_rs1_addr = '0; id_rs2_addr = '0; ex_rd_addr = '0;
    ex_mem_read = 1'b0; br_taken = 1'b0; br_target = '0; if_busy = 1'b0; mem_busy = 1'b0;
    #1;
    chk("rst_pc", redirect_pc, 32'h8000_0000);
    // outputs must stay quiet in reset even with a hazard and a branch presented
    br_taken = 1'b1; br_target = 32'h8000_0500; mem_busy = 1'b1; if_busy = 1'b1;
    #1;
    chk("rst_ctrl", 32'(ctrl), 32'h0);
    chk("rst_rv", 32'(redirect_valid), 32'h0);
    cyc(); cyc();
    br_taken = 1'b0; mem_busy = 1'b0; if_busy = 1'b0;
    reset = 1'b0;
    chk_all("idle", 10'b00_00_00_00_00, 1'b0, 32'h8000_0000);
`ifdef PIPE_HAZARD_PERF_EN
    chk("cnt_rst_stall", stall_cycles, 32'd0);
    chk("cnt_rst_lu", load_use_cnt, 32'd0);
`endif
    cyc();
    ex_mem_read = 1'b1; ex_rd_addr = 5'd5; id_rs2_addr = 5'd5;
    chk_all("lu_rs2", 10'b01_01_10_00_00, 1'b0, 32'h8000_0000);
    cyc();
    ex_rd_addr = 5'd0; id_rs1_addr = 5'd0; id_rs2_addr = 5'd5;
    chk_all("lu_x0", 10'b00_00_00_00_00, 1'b0, 32'h8000_0000);
    cyc();
    ex_rd_addr = 5'd7; id_rs1_addr = 5'd5; id_rs2_addr = 5'd6;
    chk_all("lu_nomatch", 10'b00_00_00_00_00, 1'b0, 32'h8000_0000);
    cyc();
    ex_mem_read = 1'b0; if_busy = 1'b1;
    chk_all("ifbusy", 10'b01_10_00_00_00, 1'b0, 32'h8000_0000);
    cyc();
    if_busy = 1'b0; br_taken = 1'b1; br_target = 32'h8000_0100;
    chk_all("br_idle", 10'b00_10_10_10_00, 1'b1, 32'h8000_0100);
    cyc();
    br_taken = 1'b0; br_target = 32'h0;
    chk_all("br_after", 10'b00_00_00_00_00, 1'b0, 32'h8000_0100);
`ifdef PIPE_HAZARD_PERF_EN
    chk("cnt_lu", load_use_cnt, 32'd1);
    chk("cnt_flush", flush_events, 32'd1);
    chk("cnt_stall", stall_cycles, 32'd2);
`endif
    cyc();
    ex_mem_read = 1'b1; ex_rd_addr = 5'd9; id_rs1_addr = 5'd9; id_rs2_addr = 5'd0;
    chk_all("lu_rs1", 10'b01_01_10_00_00, 1'b0, 32'h8000_0100);
    cyc();
    ex_mem_read = 1'b0;
    br_taken = 1'b1; if_busy = 1'b1; br_target = 32'h8000_0040;
    chk_all("fetch_c1", 10'b01_10_10_10_00, 1'b0, 32'h8000_0040);
    cyc();
    br_target = 32'h8000_0999;
    chk_all("fetch_c2_ign", 10'b01_10_10_10_00, 1'b0, 32'h8000_0040);
    cyc();
    br_taken = 1'b0;
    chk_all("fetch_c3", 10'b01_10_10_10_00, 1'b0, 32'h8000_0040);
    cyc();
    if_busy = 1'b0;
    chk_all("fetch_redir", 10'b00_10_10_10_00, 1'b1, 32'h8000_0040);
    cyc();
    chk_all("fetch_done", 10'b00_00_00_00_00, 1'b0, 32'h8000_0040);
    cyc();
    mem_busy = 1'b1; br_taken = 1'b1; br_target = 32'h8000_0200;
    chk_all("mem_c1", 10'b01_01_01_01_10, 1'b0, 32'h8000_0200);
    cyc();
    br_taken = 1'b0;
    chk_all("mem_c2", 10'b01_01_01_01_10, 1'b0, 32'h8000_0200);
    cyc();
    ex_mem_read = 1'b1; ex_rd_addr = 5'd3; id_rs1_addr = 5'd3;
    chk_all("mem_c3_lu", 10'b01_01_01_01_10, 1'b0, 32'h8000_0200);
    cyc();
    ex_mem_read = 1'b0;
    chk_all("mem_c4", 10'b01_01_01_01_10, 1'b0, 32'h8000_0200);
    cyc();
    mem_busy = 1'b0;
    chk_all("mem_redir", 10'b00_10_10_10_00, 1'b1, 32'h8000_0200);
    cyc();
    chk_all("mem_done", 10'b00_00_00_00_00, 1'b0, 32'h8000_0200);
    cyc();
    br_taken = 1'b1; if_busy = 1'b1; br_target = 32'h8000_0300;
    chk_all("rw_enter", 10'b01_10_10_10_00, 1'b0, 32'h8000_0300);
    cyc();
    br_taken = 1'b0;
    reset = 1'b1;
    chk_all("rw_rst", 10'b00_00_00_00_00, 1'b0, 32'h8000_0000);
    cyc();
    reset = 1'b0; if_busy = 1'b0;
    chk_all("rw_post", 10'b00_00_00_00_00, 1'b0, 32'h8000_0000);
    cyc();
    chk_all("rw_post2", 10'b00_00_00_00_00, 1'b0, 32'h8000_0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
